// File: rtl/equiv_sweep_pkg.sv
// Shared definitions for the equivalence sweep block: FSM encoding and
// vector-order mode constants.
package equiv_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic MODE_BIN  = 1'b0;
  localparam logic MODE_GRAY = 1'b1;

endpackage

// File: rtl/equiv_sweep_bin2gray.sv
// Combinational binary-to-reflected-Gray converter.
module bin2gray
  import equiv_sweep_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] bin,
  output logic [N-1:0] gray
);

  // Each Gray bit is the XOR of adjacent binary bits; the MSB passes through.
  always_comb begin
    gray = bin ^ (bin >> 1);
  end

endmodule

// File: rtl/equiv_sweep.sv
// Exhaustive equivalence sweep: drives every N-bit vector (binary or Gray
// order) to two implementations, lets each settle for DWELL cycles, then
// compares their outputs for one cycle and accumulates mismatch statistics.
module equiv_sweep
  import equiv_sweep_pkg::*;
#(
  parameter int N     = 4,
  parameter int DWELL = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic         mode,
  output logic [N-1:0] vec,
  input  logic         f_a,
  input  logic         f_b,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_cnt,
  output logic [N-1:0] first_err_vec,
  output logic         first_err_valid
);

  localparam logic [7:0]   DWELL_LAST = 8'(DWELL - 1);
  localparam logic [N-1:0] IDX_LAST   = {N{1'b1}};
  localparam logic [N:0]   ERR_ONE    = {{N{1'b0}}, 1'b1};

  state_e       state_q, state_d;
  logic [N-1:0] idx_q, idx_d;
  logic         mode_q, mode_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [N:0]   err_cnt_q, err_cnt_d;
  logic [N-1:0] fev_q, fev_d;
  logic         fevv_q, fevv_d;
  logic [N-1:0] vec_q, vec_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         pass_q, pass_d;
  logic [N-1:0] gray_s;

  // Gray form of the next index so vec can be registered alongside it.
  bin2gray #(.N(N)) u_bin2gray (
    .bin  (idx_d),
    .gray (gray_s)
  );

  // Next-state, sweep bookkeeping and registered-output precomputation.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mode_d    = mode_q;
    cnt_d     = cnt_q;
    err_cnt_d = err_cnt_q;
    fev_d     = fev_q;
    fevv_d    = fevv_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start && !abort) begin
          state_d   = ST_DRIVE;
          idx_d     = '0;
          mode_d    = mode;
          cnt_d     = 8'd0;
          err_cnt_d = '0;
          fev_d     = '0;
          fevv_d    = 1'b0;
        end else if (start && abort) begin
          // Abort wins over a simultaneous start; results are left untouched.
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      ST_DRIVE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == DWELL_LAST) begin
          state_d = ST_CHECK;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_CHECK: begin
        if (abort) begin
          // An aborted compare cycle must not disturb the partial results.
          state_d = ST_IDLE;
        end else begin
          if (f_a != f_b) begin
            err_cnt_d = err_cnt_q + ERR_ONE;
            if (!fevv_q) begin
              fev_d  = vec_q;
              fevv_d = 1'b1;
            end else begin
              fev_d = fev_q;
            end
          end else begin
            err_cnt_d = err_cnt_q;
          end
          if (idx_q == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + {{(N-1){1'b0}}, 1'b1};
            state_d = ST_DRIVE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    vec_d  = (mode_d == MODE_GRAY) ? gray_s : idx_d;
    busy_d = (state_d == ST_DRIVE) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (err_cnt_d == '0);
  end

  // State and result registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      mode_q    <= MODE_BIN;
      cnt_q     <= 8'd0;
      err_cnt_q <= '0;
      fev_q     <= '0;
      fevv_q    <= 1'b0;
      vec_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mode_q    <= mode_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
      fev_q     <= fev_d;
      fevv_q    <= fevv_d;
      vec_q     <= vec_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign vec             = vec_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_cnt         = err_cnt_q;
  assign first_err_vec   = fev_q;
  assign first_err_valid = fevv_q;

endmodule

// File: tb/tb_equiv_sweep.sv
// Scoreboard bench for equiv_sweep (N=4, DWELL=4): stimulus pushes expected
// run results and vector sequences; monitors pop and compare on DUT events.
module tb_equiv_sweep;
  import equiv_sweep_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic       abort;
  logic       mode;
  logic [3:0] vec;
  logic       f_a;
  logic       f_b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_cnt;
  logic [3:0] first_err_vec;
  logic       first_err_valid;

  typedef struct {
    logic [4:0] err;
    logic [3:0] fev;
    logic       fevv;
    logic       pass;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] vexp_q[$];
  int         n_total;
  int         n_pass;
  int         fsel;
  logic       vec_chk_en;

  equiv_sweep #(.N(4), .DWELL(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .abort           (abort),
    .mode            (mode),
    .vec             (vec),
    .f_a             (f_a),
    .f_b             (f_b),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .err_cnt         (err_cnt),
    .first_err_vec   (first_err_vec),
    .first_err_valid (first_err_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Two models of the implementation pair; fsel picks how B differs from A.
  assign f_a = vec[0] ^ vec[2];
  always_comb begin
    f_b = f_a;
    case (fsel)
      0:       f_b = f_a;
      1:       f_b = f_a ^ (vec == 4'hB);
      default: f_b = ~f_a;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: result check on done rise, vector order check while busy.
  logic prev_busy, prev_done;
  logic [3:0] prev_vec;
  int   cyc;
  initial begin
    prev_busy = 1'b0; prev_done = 1'b0; prev_vec = 4'h0; cyc = 0;
    forever begin
      @(negedge clk);
      if (busy) cyc = prev_busy ? cyc + 1 : 1;
      if (vec_chk_en && busy && (!prev_busy || vec != prev_vec)) begin
        if (vexp_q.size() == 0) chk("vec_unexpected", 32'(vec), 32'hFFFF);
        else chk("vec_seq", 32'(vec), 32'(vexp_q.pop_front()));
      end
      if (done && !prev_done) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", 32'(done), 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("err_cnt", 32'(err_cnt), 32'(e.err));
          chk("first_err_vec", 32'(first_err_vec), 32'(e.fev));
          chk("first_err_valid", 32'(first_err_valid), 32'(e.fevv));
          chk("pass", 32'(pass), 32'(e.pass));
          chk("run_cycles", 32'(cyc), 32'(e.cyc));
        end
      end
      prev_busy = busy; prev_done = done; prev_vec = vec;
    end
  end

  // Issue a start at the next edge; flip mode afterwards to prove it is latched.
  task automatic run_start(input logic m);
    mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; mode = ~m;
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (!done) chk("done_timeout", 32'(done), 32'h1);
  endtask

  task automatic push_exp(input logic [4:0] e, input logic [3:0] v, input logic vv, input logic p);
    exp_t x;
    x.err = e; x.fev = v; x.fevv = vv; x.pass = p; x.cyc = 80;
    exp_q.push_back(x);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_vec"}, 32'(vec), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_pass"}, 32'(pass), 32'h0);
    chk({tag, "_err"}, 32'(err_cnt), 32'h0);
    chk({tag, "_fev"}, 32'(first_err_vec), 32'h0);
    chk({tag, "_fevv"}, 32'(first_err_valid), 32'h0);
  endtask

  logic [3:0] gray_seq [16];

  initial begin
    n_total = 0; n_pass = 0; fsel = 0; vec_chk_en = 1'b0;
    start = 1'b0; abort = 1'b0; mode = 1'b0; rst = 1'b0;
    gray_seq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Matching implementations, binary order.
    fsel = 0;
    push_exp(5'd0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) vexp_q.push_back(4'(i));
    vec_chk_en = 1'b1;
    run_start(MODE_BIN);
    wait_done();
    vec_chk_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("done_hold", 32'(done), 32'h1);
    chk("pass_hold", 32'(pass), 32'h1);
    chk("busy_in_done", 32'(busy), 32'h0);

    // Single mismatch at vector B.
    fsel = 1;
    push_exp(5'd1, 4'hB, 1'b1, 1'b0);
    run_start(MODE_BIN);
    wait_done();

    // Restart from a failing DONE clears results on the accept edge; Gray order, all mismatch.
    fsel = 2;
    push_exp(5'd16, 4'h0, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) vexp_q.push_back(gray_seq[i]);
    vec_chk_en = 1'b1;
    run_start(MODE_GRAY);
    chk("restart_err_clr", 32'(err_cnt), 32'h0);
    chk("restart_fevv_clr", 32'(first_err_valid), 32'h0);
    chk("restart_busy", 32'(busy), 32'h1);
    chk("restart_done", 32'(done), 32'h0);
    wait_done();
    vec_chk_en = 1'b0;
    chk("gray_last_vec", 32'(vec), 32'h8);

    // Start together with abort in DONE goes to IDLE and keeps results.
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    chk("sa_done", 32'(done), 32'h0);
    chk("sa_busy", 32'(busy), 32'h0);
    chk("sa_err_hold", 32'(err_cnt), 32'h10);
    @(posedge clk); #1;
    chk("sa_stays_idle", 32'(busy), 32'h0);

    // Abort on edge 30 (a compare cycle): five compares completed.
    fsel = 2;
    run_start(MODE_BIN);
    repeat (29) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_done", 32'(done), 32'h0);
    chk("abort_err", 32'(err_cnt), 32'h5);
    chk("abort_fev", 32'(first_err_vec), 32'h0);
    chk("abort_fevv", 32'(first_err_valid), 32'h1);
    repeat (3) @(posedge clk);
    #1 chk("abort_idle_hold", 32'(err_cnt), 32'h5);

    // Asynchronous reset mid-run, then a clean full run.
    fsel = 2;
    run_start(MODE_GRAY);
    repeat (17) @(posedge clk);
    #3 rst = 1'b1;
    #1 chk_all_zero("async_rst");
    #2 rst = 1'b0;
    @(posedge clk); #1;
    fsel = 0;
    push_exp(5'd0, 4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) vexp_q.push_back(4'(i));
    vec_chk_en = 1'b1;
    run_start(MODE_BIN);
    wait_done();
    vec_chk_en = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    chk("vexp_q_drained", 32'(vexp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
